// File: rtl/ref_note_sequencer_pkg.sv
// Shared types for the reference-song sequencer: grade letter codes, song entry layout,
// end-marker value and FSM state encoding.
package ref_note_sequencer_pkg;

  localparam int NOTE_W  = 10;
  localparam int DUR_W   = 4;
  localparam int IDX_W   = 5;
  localparam int GRADE_W = 6;

  localparam logic [GRADE_W-1:0] LetterS = 6'b010010;
  localparam logic [GRADE_W-1:0] LetterA = 6'b001100;
  localparam logic [GRADE_W-1:0] LetterB = 6'b000110;
  localparam logic [GRADE_W-1:0] LetterC = 6'b000101;
  localparam logic [GRADE_W-1:0] LetterD = 6'b000011;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  // A zero duration marks the end of a song; the note field is don't-care.
  localparam logic [DUR_W-1:0] END_DUR  = '0;
  localparam entry_t           END_MARK = '{note: '0, dur: END_DUR};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic logic is_end(input entry_t e);
    return e.dur == END_DUR;
  endfunction

endpackage

// File: rtl/ref_note_sequencer_song_rom.sv
// Combinational song table indexed by {song, entry index}; returns {note, dur}.
// Song 3 is unused and returns the end marker at index 0.
module ref_note_sequencer_song_rom
  import ref_note_sequencer_pkg::*;
(
  input  logic [1:0]       i_song,
  input  logic [IDX_W-1:0] i_idx,
  output entry_t           o_entry
);

  always_comb begin
    o_entry = END_MARK;
    case (i_song)
      2'd0: begin
        case (i_idx)
          5'd0:    o_entry = '{note: 10'b0000000001, dur: 4'd2};
          5'd1:    o_entry = '{note: 10'b0000000100, dur: 4'd1};
          default: o_entry = END_MARK;
        endcase
      end
      // Full-length scale without an end marker: exercises the index wrap guard.
      2'd1: o_entry = '{note: NOTE_W'(i_idx) + NOTE_W'(1),
                        dur:  {2'b00, i_idx[1:0]} + DUR_W'(1)};
      2'd2: begin
        case (i_idx)
          5'd0:    o_entry = '{note: 10'b0000100000, dur: 4'd1};
          5'd1:    o_entry = '{note: 10'b0000100000, dur: 4'd1};
          5'd2:    o_entry = '{note: 10'b1000000000, dur: 4'd2};
          default: o_entry = END_MARK;
        endcase
      end
      default: o_entry = END_MARK;
    endcase
  end

endmodule

// File: rtl/ref_note_sequencer.sv
// Reference song player: expected-key bus paced by a beat timer, grade capture at song end.
// First note two cycles after start; `define SEQ_GAP_EN inserts a GAP_CYC-cycle rest between notes.
module ref_note_sequencer
  import ref_note_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int MAX_LEN  = 32,
  parameter int GAP_CYC  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         song_sel,
  input  logic [1:0]         user_sel,
  input  logic [GRADE_W-1:0] grade_in,
  output logic [NOTE_W-1:0]  store,
  output logic               note_valid,
  output logic [IDX_W-1:0]   note_idx,
  output logic               song_done,
  output logic               busy,
  output logic [GRADE_W-1:0] grade_u1,
  output logic [GRADE_W-1:0] grade_u2,
  output logic [GRADE_W-1:0] grade_u3
);

  localparam int               TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(MAX_LEN - 1);

  state_t             r_state;
  logic [1:0]         r_song;
  logic [1:0]         r_user;
  logic [TW-1:0]      r_tick;
  logic [DUR_W-1:0]   r_beat;
  entry_t             w_entry;
  logic               w_tick;
  logic               w_last_beat;
  logic               w_load;

  ref_note_sequencer_song_rom u_song_rom (
    .i_song  (r_song),
    .i_idx   (note_idx),
    .o_entry (w_entry)
  );

  assign w_tick      = (r_tick == TICK_LAST);
  assign w_last_beat = w_tick && (r_beat == DUR_W'(1));

`ifdef SEQ_GAP_EN
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  logic [GW-1:0] r_gap;
  // The final rest cycle already fetches the next entry, so the rest is exactly GAP_CYC cycles.
  assign w_load = (r_state == ST_LOAD) ||
                  ((r_state == ST_GAP) && (r_gap == GW'(GAP_CYC - 1)));
`else
  assign w_load = (r_state == ST_LOAD);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_song     <= '0;
      r_user     <= '0;
      r_tick     <= '0;
      r_beat     <= '0;
      store      <= '0;
      note_valid <= 1'b0;
      note_idx   <= '0;
      song_done  <= 1'b0;
      busy       <= 1'b0;
      grade_u1   <= LetterD;
      grade_u2   <= LetterD;
      grade_u3   <= LetterD;
`ifdef SEQ_GAP_EN
      r_gap      <= '0;
`endif
    end else if (abort) begin
      r_state    <= ST_IDLE;
      store      <= '0;
      note_valid <= 1'b0;
      song_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      song_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_song   <= song_sel;
            r_user   <= user_sel;
            note_idx <= '0;
            busy     <= 1'b1;
            r_state  <= ST_LOAD;
          end
        end
        ST_PLAY: begin
          r_tick <= w_tick ? '0 : r_tick + TW'(1);
          if (w_tick) r_beat <= r_beat - DUR_W'(1);
          if (w_last_beat) begin
            if (note_idx == IDX_LAST) begin
              r_state    <= ST_DONE;
              store      <= '0;
              note_valid <= 1'b0;
              song_done  <= 1'b1;
            end else begin
              note_idx <= note_idx + IDX_W'(1);
`ifdef SEQ_GAP_EN
              r_state    <= ST_GAP;
              store      <= '0;
              note_valid <= 1'b0;
              r_gap      <= '0;
`else
              r_state  <= ST_LOAD;
`endif
            end
          end
        end
        ST_DONE: begin
          case (r_user)
            2'b00:   grade_u1 <= grade_in;
            2'b01:   grade_u2 <= grade_in;
            2'b10:   grade_u3 <= grade_in;
            default: ;
          endcase
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: ;
      endcase
`ifdef SEQ_GAP_EN
      if (r_state == ST_GAP) r_gap <= r_gap + GW'(1);
`endif
      if (w_load) begin
        r_tick <= '0;
        if (is_end(w_entry)) begin
          r_state    <= ST_DONE;
          store      <= '0;
          note_valid <= 1'b0;
          song_done  <= 1'b1;
        end else begin
          store      <= w_entry.note;
          note_valid <= 1'b1;
          r_beat     <= w_entry.dur;
          r_state    <= ST_PLAY;
        end
      end
    end
  end

endmodule
